// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run controller.
//   - FSM state encodings (also driven out on the mode port)
//   - default parameter values for the controller and button conditioners
//   - counter width helper
package cpu_ctrl_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t ST_HOLD = 2'd0;
  localparam mode_t ST_HALT = 2'd1;
  localparam mode_t ST_RUN  = 2'd2;
  localparam mode_t ST_STEP = 2'd3;

  localparam int unsigned RUN_DIV_DEF     = 50000000;
  localparam int unsigned DEB_CYCLES_DEF  = 1000000;
  localparam int unsigned HOLD_CYCLES_DEF = 4;

  // Bits needed to hold the values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, debouncer, rising-edge pulse.
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   btn_i    raw button, asynchronous to clk
//   pulse_o  one-cycle pulse when the debounced level rises
module btn_conditioner
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int unsigned   DW       = cnt_width(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_dly_q;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;

  // For a single-bit input, "differs from the accepted level" is the same as
  // "has not changed since it started to differ": any bounce back makes it
  // equal again, which restarts the count.
  always_comb begin
    deb_cnt_d = '0;
    level_d   = level_q;
    if (sync2_q != level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        level_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      deb_cnt_q   <= '0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      deb_cnt_q   <= deb_cnt_d;
    end
  end

  assign pulse_o = level_q & ~level_dly_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt controller for a pipelined CPU driven by a clock enable.
// Ports:
//   clk, rst                    system clock, asynchronous active-low reset
//   btn_run/btn_step/btn_halt   raw push-buttons
//   bp_en, bp_addr              breakpoint enable and PC
//   pc_f                        CPU fetch PC
//   cpu_en                      one-cycle advance pulse
//   cpu_rst                     active-high CPU reset
//   mode                        state register
//   step_count                  number of cpu_en pulses issued (wraps)
//
// state | meaning
// HOLD  | CPU held in reset for HOLD_CYCLES after reset release
// HALT  | CPU stopped, waiting for a button
// RUN   | cpu_en every RUN_DIV cycles until halt or breakpoint
// STEP  | single cpu_en cycle, then back to HALT
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned RUN_DIV     = RUN_DIV_DEF,
  parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic        btn_halt,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc_f,
  output logic        cpu_en,
  output logic        cpu_rst,
  output logic [1:0]  mode,
  output logic [15:0] step_count
);

  localparam int unsigned   PW         = cnt_width(RUN_DIV);
  localparam int unsigned   HW         = cnt_width(HOLD_CYCLES);
  localparam logic [PW-1:0] PRESC_LAST = PW'(RUN_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);

  logic          run_p, step_p, halt_p;
  mode_t         state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          bp_hit_q;
  logic          cpu_rst_q;
  logic [15:0]   step_count_q;
  logic          presc_last;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_run (
    .clk(clk), .rst(rst), .btn_i(btn_run), .pulse_o(run_p)
  );
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_step (
    .clk(clk), .rst(rst), .btn_i(btn_step), .pulse_o(step_p)
  );
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_halt (
    .clk(clk), .rst(rst), .btn_i(btn_halt), .pulse_o(halt_p)
  );

  assign presc_last = (presc_q == PRESC_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD: if (hold_cnt_q == '0) state_d = ST_HALT;
      ST_HALT: begin
        if (halt_p)      state_d = ST_HALT;
        else if (step_p) state_d = ST_STEP;
        else if (run_p)  state_d = ST_RUN;
      end
      ST_STEP: state_d = ST_HALT;
      ST_RUN:  if (halt_p || (presc_last && bp_hit_q)) state_d = ST_HALT;
      default: state_d = ST_HOLD;
    endcase
  end

  // Prescaler sits at zero outside RUN, so every entry to RUN starts at 0.
  assign presc_d    = (state_q == ST_RUN && !presc_last) ? presc_q + PW'(1) : '0;
  assign hold_cnt_d = (state_q == ST_HOLD && hold_cnt_q != '0) ? hold_cnt_q - HW'(1) : hold_cnt_q;

  // The breakpoint compare is registered to keep inputs off the cpu_en path.
  // The CPU only moves on cpu_en, and pulses in RUN are at least two cycles
  // apart, so pc_f one cycle before a would-be pulse is the PC of that pulse.
  assign cpu_en = (state_q == ST_STEP) ||
                  (state_q == ST_RUN && presc_last && !bp_hit_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_HOLD;
      presc_q      <= '0;
      hold_cnt_q   <= HOLD_LOAD;
      bp_hit_q     <= 1'b0;
      cpu_rst_q    <= 1'b1;
      step_count_q <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      hold_cnt_q <= hold_cnt_d;
      bp_hit_q   <= bp_en && (pc_f == bp_addr);
      cpu_rst_q  <= (state_d == ST_HOLD);
      if (cpu_en) step_count_q <= step_count_q + 16'd1;
    end
  end

  assign cpu_rst    = cpu_rst_q;
  assign mode       = state_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

  localparam int unsigned RUN_DIV = 4;
  localparam int unsigned DEB     = 3;
  localparam int unsigned HOLD    = 4;

  localparam logic [1:0] M_HOLD = 2'd0;
  localparam logic [1:0] M_HALT = 2'd1;
  localparam logic [1:0] M_RUN  = 2'd2;
  localparam logic [1:0] M_STEP = 2'd3;

  // button masks: {halt, step, run}
  localparam logic [2:0] B_RUN  = 3'b001;
  localparam logic [2:0] B_STEP = 3'b010;
  localparam logic [2:0] B_HALT = 3'b100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_run = 1'b0, btn_step = 1'b0, btn_halt = 1'b0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = '0, pc_f = '0;
  logic        cpu_en, cpu_rst;
  logic [1:0]  mode;
  logic [15:0] step_count;

  cpu_run_ctrl #(.RUN_DIV(RUN_DIV), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst),
    .btn_run(btn_run), .btn_step(btn_step), .btn_halt(btn_halt),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc_f(pc_f),
    .cpu_en(cpu_en), .cpu_rst(cpu_rst), .mode(mode), .step_count(step_count)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] exp_q[$];        // expected mode of each required pulse
  bit         run_window = 0;  // RUN pulses tolerated while a halt press propagates
  int         preload_req = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops one expectation per observed cpu_en pulse and
  // keeps its own pulse count as the reference for step_count.
  task automatic monitor();
    logic [15:0] mdl_cnt = '0;
    int          run_cyc = 0;
    bit          pend = 0;
    int          pre_seen = 0;
    int          cyc = 0;
    logic [1:0]  e;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc > 60000) begin
        $display("FAIL watchdog: cycle %0d exceeds limit 60000", cyc);
        $fatal(1, "watchdog");
      end
      if (!rst) begin
        mdl_cnt = '0;
        run_cyc = 0;
        pend    = 0;
      end else begin
        if (pend) chk("step_count", step_count, mdl_cnt);
        pend = 0;
        if (pre_seen != preload_req) begin
          pre_seen = preload_req;
          mdl_cnt  = 16'hFFFF;
        end
        run_cyc = (mode == M_RUN) ? run_cyc + 1 : 0;
        if (cpu_en) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pulse_mode", mode, e);
          end else if (!(run_window && mode == M_RUN)) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pulse: cpu_en=1 in mode %0d, none expected (t=%0t)", mode, $time);
          end
          // a RUN pulse lands on RUN cycle RUN_DIV, 2*RUN_DIV, ... after entry
          if (mode == M_RUN) chk("run_phase", run_cyc % RUN_DIV, 0);
          mdl_cnt++;
          pend = 1;
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle();
    tick(DEB + 6);
  endtask

  task automatic set_btns(input logic [2:0] m);
    {btn_halt, btn_step, btn_run} = m;
  endtask

  task automatic press(input logic [2:0] m, input int len);
    set_btns(m);
    tick(len);
    set_btns(3'b000);
  endtask

  task automatic wait_mode(input string name, input logic [1:0] m, input int budget);
    int i = 0;
    while (mode !== m && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(name, mode, m);
    if (mode === m) chk({name, "_cpu_rst"}, cpu_rst, (m == M_HOLD));
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i = 0;
    while (exp_q.size() > 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk({"drain_", name}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Releases reset at a negedge; counts the HOLD cycles including the one in
  // progress at release, i.e. the rising edges the CPU sees with cpu_rst high.
  task automatic release_check_hold();
    int n = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    while (mode === M_HOLD && n < HOLD + 10) begin
      n++;
      chk("hold_cpu_rst", cpu_rst, 1);
      chk("hold_no_en", cpu_en, 0);
      chk("hold_count", step_count, 0);
      @(negedge clk);
    end
    chk("hold_len", n, HOLD);
    chk("after_hold_mode", mode, M_HALT);
    chk("after_hold_cpu_rst", cpu_rst, 0);
  endtask

  task automatic do_step(input logic [2:0] m);
    exp_q.push_back(M_STEP);
    press(m, $urandom_range(DEB + 1, 10));
    wait_drain("step", 40);
    wait_mode("step_to_halt", M_HALT, 5);
    settle();
  endtask

  task automatic run_halt(input int n);
    repeat (n) exp_q.push_back(M_RUN);
    press(B_RUN, $urandom_range(DEB + 1, 8));
    wait_drain("run", n * RUN_DIV + 30);
    run_window = 1;
    press(B_HALT, $urandom_range(DEB + 1, 8));
    wait_mode("halt_from_run", M_HALT, 30);
    run_window = 0;
    settle();
    chk("halted_mode", mode, M_HALT);
  endtask

  initial begin
    int i;
    fork
      monitor();
    join_none

    // reset state
    tick(3);
    chk("rst_mode", mode, M_HOLD);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_count", step_count, 0);
    release_check_hold();
    settle();

    // single step from a long press, then a glitch that must not register
    do_step(B_STEP);
    chk("count_after_step", step_count, 1);
    press(B_STEP, 2);
    tick(20);
    chk("glitch_mode", mode, M_HALT);
    press(B_STEP, 1);
    tick(20);
    chk("glitch1_mode", mode, M_HALT);

    // RUN for 10 pulses, then halt
    run_halt(10);

    // breakpoint hit: the would-be pulse is dropped and RUN ends after RUN_DIV cycles
    bp_en = 1'b1;
    bp_addr = 32'h0000_0010;
    pc_f = 32'h0000_0010;
    tick(2);
    btn_run = 1'b1;
    wait_mode("bp_enter_run", M_RUN, 20);
    i = 0;
    while (mode === M_RUN && i < RUN_DIV + 5) begin
      tick(1);
      i++;
    end
    chk("bp_run_len", i, RUN_DIV);
    chk("bp_mode", mode, M_HALT);
    btn_run = 1'b0;
    settle();
    do_step(B_STEP);  // stepping past a matching PC still issues a pulse
    bp_en = 1'b0;

    // simultaneous presses in HALT
    press(B_HALT | B_STEP, $urandom_range(DEB + 1, 8));
    tick(15);
    chk("halt_step_mode", mode, M_HALT);
    settle();
    press(B_HALT | B_RUN, $urandom_range(DEB + 1, 8));
    tick(15);
    chk("halt_run_mode", mode, M_HALT);
    settle();
    do_step(B_STEP | B_RUN);

    // randomized mix, breakpoint armed on a near-miss PC
    repeat (8) begin
      bp_en   = 1'($urandom_range(0, 1));
      bp_addr = $urandom;
      pc_f    = bp_addr ^ (32'h1 << $urandom_range(0, 31));
      case ($urandom_range(0, 4))
        0: do_step(B_STEP);
        1: run_halt($urandom_range(1, 5));
        2: begin
          press(B_STEP, $urandom_range(1, 2));
          tick(20);
          chk("rnd_glitch_mode", mode, M_HALT);
        end
        3: begin
          press(B_HALT | B_STEP, $urandom_range(DEB + 1, 8));
          tick(15);
          chk("rnd_halt_step_mode", mode, M_HALT);
          settle();
        end
        default: do_step(B_STEP | B_RUN);
      endcase
    end
    bp_en = 1'b0;

    // step_count wrap
    @(negedge clk);
    force dut.step_count_q = 16'hFFFF;
    preload_req++;
    tick(1);
    release dut.step_count_q;
    tick(2);
    do_step(B_STEP);
    chk("wrap_count", step_count, 16'h0000);

    // reset one cycle before a RUN pulse
    run_window = 1;
    btn_run = 1'b1;
    wait_mode("rr_enter_run", M_RUN, 20);
    btn_run = 1'b0;
    i = 0;
    while (cpu_en !== 1'b1 && i < 20) begin
      tick(1);
      i++;
    end
    chk("rr_pulse_seen", cpu_en, 1);
    tick(RUN_DIV - 1);
    rst = 1'b0;
    #1;
    chk("rr_mode", mode, M_HOLD);
    chk("rr_cpu_en", cpu_en, 0);
    chk("rr_count", step_count, 0);
    chk("rr_cpu_rst", cpu_rst, 1);
    for (int k = 0; k < int'(RUN_DIV) + 2; k++) begin
      tick(1);
      chk("rr_no_pulse", cpu_en, 0);
    end
    run_window = 0;
    release_check_hold();
    tick(10);
    chk("final_count", step_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
